// File: rtl/mult_cell_seq_arb.sv
// Round-robin sequencer sharing one three-product 16x16 multiplier cell between two requesters.
// Optional feature macro MULT_SEQ_HI_EN adds the ISSUE_HI/CAPT_HI pass for the full 64-bit product.
module mult_cell_seq_arb #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [31:0]     req0_a,
  input  logic [31:0]     req0_b,
  input  logic            req0_hi,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [31:0]     req1_a,
  input  logic [31:0]     req1_b,
  input  logic            req1_hi,
  output logic [31:0]     mul_src1,
  output logic [31:0]     mul_src2,
  output logic            mul_en,
  input  logic [31:0]     mul_p1,
  input  logic [31:0]     mul_p2,
  input  logic [31:0]     mul_p3,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic [31:0]     rsp_lo,
  output logic [31:0]     rsp_hi
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    CAPT     = 3'd2,
    ISSUE_HI = 3'd3,
    CAPT_HI  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t           state_r;
  logic [PTR_W-1:0] rr_r;
  logic             run_r;
  logic [31:0]      a_r;
  logic [31:0]      b_r;
  logic             hi_r;
  logic [ID_W-1:0]  id_r;
  logic [63:0]      acc_r;

  logic             grant_s;
  logic             take_s;
  logic             go_hi_s;
  logic [31:0]      sel_a_s;
  logic [31:0]      sel_b_s;
  logic             sel_hi_s;
  logic [32:0]      mid_sum_s;
  logic [48:0]      capt_sum_s;
  logic [63:0]      hi_sum_s;

  // Arbitration, handshake and product assembly.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant_s = rr_r[0];
    end else begin
      grant_s = req1_valid;
    end
    // run_r keeps both readies low while reset is asserted
    take_s     = run_r && (state_r == IDLE) && (req0_valid || req1_valid);
    req0_ready = take_s && !grant_s;
    req1_ready = take_s && grant_s;
    if (grant_s) begin
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
      sel_hi_s = req1_hi;
    end else begin
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
      sel_hi_s = req0_hi;
    end
    mid_sum_s  = {1'b0, mul_p2} + {1'b0, mul_p3};
    capt_sum_s = {17'h0, mul_p1} + {mid_sum_s, 16'h0};
    hi_sum_s   = acc_r + {mul_p1, 32'h0};
  end

`ifdef MULT_SEQ_HI_EN
  assign go_hi_s = hi_r;
`else
  assign go_hi_s = 1'b0;
  logic unused_s;
  assign unused_s = ^{hi_r, hi_sum_s};
`endif

  // Sequencer FSM with registered cell-side and response-side outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      rr_r      <= {PTR_W{1'b0}};
      run_r     <= 1'b0;
      a_r       <= 32'h0;
      b_r       <= 32'h0;
      hi_r      <= 1'b0;
      id_r      <= {ID_W{1'b0}};
      acc_r     <= 64'h0;
      mul_src1  <= 32'h0;
      mul_src2  <= 32'h0;
      mul_en    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= {ID_W{1'b0}};
      rsp_lo    <= 32'h0;
      rsp_hi    <= 32'h0;
    end else begin
      run_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (take_s) begin
            a_r      <= sel_a_s;
            b_r      <= sel_b_s;
            hi_r     <= sel_hi_s;
            id_r     <= ID_W'(grant_s);
            rr_r     <= PTR_W'(~grant_s);
            mul_src1 <= sel_a_s;
            mul_src2 <= sel_b_s;
            mul_en   <= 1'b1;
            state_r  <= ISSUE;
          end else begin
            state_r  <= IDLE;
          end
        end
        ISSUE: begin
          mul_en   <= 1'b0;
          mul_src1 <= 32'h0;
          mul_src2 <= 32'h0;
          state_r  <= CAPT;
        end
        CAPT: begin
          acc_r <= {15'h0, capt_sum_s};
          if (go_hi_s) begin
            mul_src1 <= {16'h0, a_r[31:16]};
            mul_src2 <= {16'h0, b_r[31:16]};
            mul_en   <= 1'b1;
            state_r  <= ISSUE_HI;
          end else begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_r;
            rsp_lo    <= capt_sum_s[31:0];
            rsp_hi    <= 32'h0;
            state_r   <= DONE;
          end
        end
`ifdef MULT_SEQ_HI_EN
        ISSUE_HI: begin
          mul_en   <= 1'b0;
          mul_src1 <= 32'h0;
          mul_src2 <= 32'h0;
          state_r  <= CAPT_HI;
        end
        CAPT_HI: begin
          acc_r     <= hi_sum_s;
          rsp_valid <= 1'b1;
          rsp_id    <= id_r;
          rsp_lo    <= hi_sum_s[31:0];
          rsp_hi    <= hi_sum_s[63:32];
          state_r   <= DONE;
        end
`endif
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_id    <= {ID_W{1'b0}};
            rsp_lo    <= 32'h0;
            rsp_hi    <= 32'h0;
            state_r   <= IDLE;
          end else begin
            state_r   <= DONE;
          end
        end
        default: begin
          mul_en    <= 1'b0;
          mul_src1  <= 32'h0;
          mul_src2  <= 32'h0;
          rsp_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_cell_seq_arb.md
Name: mult_cell_seq_arb

Overview:
- Sequencer and arbiter for the three-product 16x16 multiplier cell (p1 = a_lo*b_lo, p2 = a_lo*b_hi, p3 = a_hi*b_lo).
- The cell is unsigned, with registered products, an enable (ena) and an asynchronous clear.
- Shares the cell between two requesters (CPU custom-instruction port and DMA-side accelerator) using round-robin arbitration.
- Drives cell operands and enable, collects the products, and assembles the 32-bit low result (optionally the 64-bit full result) onto one response channel with backpressure.

Parameters:
- NUM_REQ, 2, number of requesters (fixed at 2; the round-robin pointer is 1 bit).
- ID_W, 1, width of rsp_id.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 handshake accepted this cycle.
- req0_a  in  32  requester 0 operand A.
- req0_b  in  32  requester 0 operand B.
- req0_hi  in  1  requester 0 wants the high word.
- req1_valid, req1_ready, req1_a, req1_b, req1_hi: same as requester 0, for requester 1.
- mul_src1  out  32  operand A to the cell.
- mul_src2  out  32  operand B to the cell.
- mul_en  out  1  cell register enable.
- mul_p1  in  32  product p1 from the cell.
- mul_p2  in  32  product p2 from the cell.
- mul_p3  in  32  product p3 from the cell.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_lo  out  32  product bits [31:0].
- rsp_hi  out  32  product bits [63:32] (0 when the high word was not computed).

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, rr_ptr=0.
  - All outputs are 0: ready, mul_en, mul_src, rsp_*.
  - Internal accumulators are cleared.
  - Reset mid-operation abandons the operation; no response is issued.
- States: IDLE, ISSUE, CAPT, ISSUE_HI, CAPT_HI, DONE.
- IDLE:
  - If any reqN_valid, grant one requester.
  - When both are valid, grant rr_ptr; otherwise grant the single requester.
  - reqN_ready=1 for exactly that cycle (combinational from state and valids).
  - Latch a, b, hi and id; rr_ptr <= ~grant; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: mul_src1=a, mul_src2=b, mul_en=1; go to CAPT.
- CAPT:
  - mul_en=0, so the cell holds its products.
  - acc[48:0] <= p1 + ((p2 + p3) << 16); the p2+p3 sum is 33 bits wide.
  - If hi is latched and MULT_SEQ_HI_EN is defined, go to ISSUE_HI; else go to DONE.
- ISSUE_HI: mul_src1={16'h0,a[31:16]}, mul_src2={16'h0,b[31:16]}, mul_en=1; go to CAPT_HI.
- CAPT_HI: acc[63:0] <= acc + (p1 << 32); go to DONE.
- DONE:
  - rsp_valid=1; rsp_lo=acc[31:0]; rsp_hi = hi ? acc[63:32] : 0.
  - rsp_id = latched id.
  - Outputs are held stable until rsp_ready=1; then go to IDLE.
  - No new grant in the same cycle as the response handshake.
- Latency from the accepting edge to rsp_valid: 3 cycles for a low-only operation, 5 cycles with the high word.
- Throughput: at most one operation in flight. Minimum spacing between grants is 4 cycles (low-only) or 6 cycles (with high word).
- mul_en is 1 only in ISSUE and ISSUE_HI. mul_src is 0 whenever mul_en=0.
- Unsigned arithmetic only; rsp_lo is correct for signed operands as well.
- A requester holding valid for multiple operations is re-granted only after the other requester's turn, if the other is pending.

Optional Feature:
- MULT_SEQ_HI_EN, defined:
  - The ISSUE_HI and CAPT_HI states exist.
  - reqN_hi=1 yields the full 64-bit unsigned product.
- MULT_SEQ_HI_EN, undefined:
  - reqN_hi is ignored, rsp_hi is tied to 0 and the HI states are not synthesised.
  - Latency is always 3 cycles.

Test Plan:
- Reset mid-CAPT: assert reset_n=0 asynchronously → all outputs 0 immediately, no rsp_valid after release, rr_ptr=0.
- Basic: req0 a=0x00012345, b=0x00000010, hi=0 → req0_ready pulses once; rsp_valid exactly 3 cycles later; rsp_lo=0x00123450, rsp_hi=0, rsp_id=0.
- Full width (HI_EN defined): req1 a=b=0xFFFFFFFF, hi=1 → rsp_valid 5 cycles after grant; rsp_lo=0x00000001, rsp_hi=0xFFFFFFFE, rsp_id=1.
- Arbitration: req0 and req1 both continuously valid with distinct operands (0x3*0x5, 0x7*0xB) → grants alternate 0,1,0,1; rsp_lo alternates 0xF, 0x4D; never two consecutive grants to one requester.
- Backpressure: hold rsp_ready=0 for 10 cycles in DONE → rsp_valid, rsp_lo and rsp_id stable; no reqN_ready; mul_en=0 throughout.
- HI_EN undefined: a=b=0xFFFFFFFF, hi=1 → latency 3 cycles, rsp_lo=0x00000001, rsp_hi=0.
